input_conditioner: RTL

//  N-channel front end for all calculator buttons and sliders.
//  - Each channel: 2-flop synchroniser, then counter-based debounce, then edge detect.
//  - Channels in REPEAT_MASK also get hold-to-repeat press pulses.
//  - Single instance sits between board pins and calculator control logic.

---
 rtl/input_conditioner_if.sv | 14 +
 rtl/input_conditioner.sv | 108 ++++++++++
 2 files changed

// File: rtl/input_conditioner_if.sv
// Pin-side and control-side signals of the input conditioner, one bit per channel.
// The board/stimulus side uses master; the conditioner uses slave.
interface input_conditioner_if #(
    parameter int N_CH = 5
);
    logic [N_CH-1:0] raw;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] press;

    modport master (output raw, input level, input rise, input fall, input press);
    modport slave  (input raw, output level, output rise, output fall, output press);
endinterface

// File: rtl/input_conditioner.sv
// N-channel button/slider front end: 2-flop sync, counter debounce, edge detect,
// and optional hold-to-repeat press pulses per channel.
module input_conditioner #(
    parameter int              N_CH         = 5,
    parameter int              DB_CYCLES    = 1000000,
    parameter logic [N_CH-1:0] REPEAT_MASK  = '0,
    parameter int              REPEAT_DELAY = 50000000,
    parameter int              REPEAT_RATE  = 10000000
) (
    input logic                clk,
    input logic                reset_n,
    input_conditioner_if.slave bus
);
    localparam int DW   = $clog2(DB_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, HELD, DELAY, REPEAT} rpt_state_t;

    logic [N_CH-1:0] level, rise, fall, press;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic          s1, s2;
        logic          lvl_q, rise_q, fall_q, press_q;
        logic [DW-1:0] dcnt;
        logic          db_hit, rise_ev, fall_ev;
        rpt_state_t    state, state_nx;
        logic [RW-1:0] rcnt, rcnt_nx;
        logic          press_nx;

        // db_hit marks the edge on which the new level is accepted
        assign db_hit  = (s2 != lvl_q) && (dcnt == DB_LAST);
        assign rise_ev = db_hit && !lvl_q;
        assign fall_ev = db_hit && lvl_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1     <= 1'b0;
                s2     <= 1'b0;
                lvl_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                dcnt   <= '0;
            end else begin
                s1     <= bus.raw[i];
                s2     <= s1;
                rise_q <= rise_ev;
                fall_q <= fall_ev;
                if (db_hit) lvl_q <= ~lvl_q;
                if (s2 == lvl_q || db_hit) dcnt <= '0;
                else                       dcnt <= dcnt + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state   <= IDLE;
                rcnt    <= '0;
                press_q <= 1'b0;
            end else begin
                state   <= state_nx;
                rcnt    <= rcnt_nx;
                press_q <= press_nx;
            end
        end

        always_comb begin
            state_nx = state;
            case (state)
                IDLE:    if (rise_ev) state_nx = REPEAT_MASK[i] ? DELAY : HELD;
                DELAY:   if (rcnt == DLY_LAST) state_nx = REPEAT;
                default: ;
            endcase
            if (fall_ev) state_nx = IDLE;
        end

        // A release on the same edge as a due repeat suppresses that repeat
        always_comb begin
            press_nx = 1'b0;
            rcnt_nx  = '0;
            case (state)
                IDLE:    press_nx = rise_ev;
                DELAY:   if (rcnt == DLY_LAST) press_nx = 1'b1;
                         else                  rcnt_nx  = rcnt + 1'b1;
                REPEAT:  if (rcnt == RATE_LAST) press_nx = 1'b1;
                         else                   rcnt_nx  = rcnt + 1'b1;
                default: ;
            endcase
            if (fall_ev) begin
                press_nx = 1'b0;
                rcnt_nx  = '0;
            end
        end

        assign level[i] = lvl_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
        assign press[i] = press_q;
    end

    assign bus.level = level;
    assign bus.rise  = rise;
    assign bus.fall  = fall;
    assign bus.press = press;
endmodule
